uart_fifo_ctrl: RTL and testbench

//  Controller for the 8-in/32-out byte-packing FIFO in the RS-232 path.
//  - Write side: arbitrates two byte requesters (UART RX, host command injector) onto the FIFO byte port.
//  - Read side: drains packed words into a registered valid/ready stream.
//  - Grants are word-atomic: a 32-bit word never mixes bytes from two sources.
//  - A stalled partial word is padded out after a timeout.
//  - Guarantees the FIFO never sees a write when full or a read when empty.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_word_drain.sv | 59 +++++
 rtl/uart_fifo_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the RS-232 byte-packing FIFO controller.
// Holds the write-FSM state encodings, the word geometry, the default pad
// byte and a small saturating-increment helper used by the pad counter.
package uart_pkg;

  // Write-side FSM state encodings
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_OWN  = 2'd1;
  localparam logic [1:0] W_PAD  = 2'd2;

  // Bytes packed into one FIFO word
  localparam int BYTES_PER_WORD = 4;

  // Byte used to complete a stalled partial word
  localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h00;

  // 8-bit increment that sticks at 8'hFF
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_word_drain.sv
// Read-side drain stage for the byte-packing FIFO.
// Pops packed words from the FIFO into a single output register and
// presents them as a valid/ready stream.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous reset, active-high
//   fifo_rdata_i  in   FIFO head word (combinational from FIFO)
//   fifo_empty_i  in   FIFO holds no complete word
//   fifo_rd_o     out  FIFO pop strobe
//   word_o        out  registered output word
//   word_valid_o  out  output word valid
//   word_ready_i  in   downstream accepts word
//
// Handshake: a word transfers on a rising clk edge where word_valid_o and
// word_ready_i are both 1. Once word_valid_o is high, word_o and
// word_valid_o hold until that transfer; word_ready_i may change freely.
module uart_word_drain (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fifo_rdata_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rd_o,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i
);

  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    // Pop whenever the register is free or is being emptied this cycle;
    // this gives back-to-back pops on consecutive accepts.
    fifo_rd_o = !fifo_empty_i && (!valid_q || word_ready_i);
    word_d    = word_q;
    valid_d   = valid_q;
    if (fifo_rd_o) begin
      word_d  = fifo_rdata_i;
      valid_d = 1'b1;
    end else if (valid_q && word_ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Controller for the 8-in/32-out byte-packing FIFO in the RS-232 path.
// Write side: round-robin, word-atomic arbitration of two byte requesters
// onto the FIFO byte port, with padding of a stalled partial word.
// Read side: uart_word_drain turns packed words into a registered stream.
//
// Ports:
//   sclk, rst                      clock, asynchronous active-high reset
//   req0_valid_i/data_i/ready_o    requester 0 (UART RX) byte handshake
//   req1_valid_i/data_i/ready_o    requester 1 (command injector) handshake
//   fifo_wdata_o, fifo_wr_o        FIFO byte write port
//   fifo_rdata_i, fifo_rd_o        FIFO word read port
//   fifo_empty_i, fifo_full_i      FIFO status
//   word_o, word_valid_o,
//   word_ready_i                   output word stream
//   owner_o                        current/last write owner
//   pad_cnt_o                      saturating count of padded words
//
// Requester handshake: a byte transfers on a rising sclk edge where
// reqN_valid_i and reqN_ready_o are both 1. Ready is only ever given to
// the owner while the FIFO is not full, so the FIFO never sees a write
// when full. The same valid/ready rule applies to the word stream.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int         PAD_TIMEOUT = 16,
  parameter logic [7:0] PAD_BYTE    = PAD_BYTE_DEFAULT
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        req0_valid_i,
  input  logic [7:0]  req0_data_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [7:0]  req1_data_i,
  output logic        req1_ready_o,
  output logic [7:0]  fifo_wdata_o,
  output logic        fifo_wr_o,
  input  logic [31:0] fifo_rdata_i,
  output logic        fifo_rd_o,
  input  logic        fifo_empty_i,
  input  logic        fifo_full_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        owner_o,
  output logic [7:0]  pad_cnt_o
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);
  localparam logic [7:0] TMO_LAST  = 8'(PAD_TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_q, rr_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] pad_cnt_q, pad_cnt_d;

  logic       owner_valid;
  logic [7:0] owner_data;
  logic       grant_rdy;
  logic       own_xfer;
  logic       pad_wr;

  // State register
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q   <= W_IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      bcnt_q    <= 2'd0;
      tmo_q     <= 8'd0;
      pad_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      bcnt_q    <= bcnt_d;
      tmo_q     <= tmo_d;
      pad_cnt_q <= pad_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    bcnt_d    = bcnt_q;
    tmo_d     = tmo_q;
    pad_cnt_d = pad_cnt_q;
    case (state_q)
      W_IDLE: begin
        // Grant only; no byte moves in the arbitration cycle.
        if (!fifo_full_i && (req0_valid_i || req1_valid_i)) begin
          owner_d = (req0_valid_i && req1_valid_i) ? rr_q : req1_valid_i;
          bcnt_d  = 2'd0;
          tmo_d   = 8'd0;
          state_d = W_OWN;
        end
      end
      W_OWN: begin
        if (own_xfer) begin
          bcnt_d = bcnt_q + 2'd1;
          tmo_d  = 8'd0;
          if (bcnt_q == LAST_BYTE) begin
            state_d = W_IDLE;
            rr_d    = ~owner_q;
          end
        end else if (tmo_q == TMO_LAST) begin
          // An empty word is simply released; a partial one is padded out.
          rr_d = ~owner_q;
          if (bcnt_q == 2'd0) begin
            state_d = W_IDLE;
          end else begin
            state_d = W_PAD;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      W_PAD: begin
        if (pad_wr) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == LAST_BYTE) begin
            pad_cnt_d = sat_inc8(pad_cnt_q);
            state_d   = W_IDLE;
            rr_d      = ~owner_q;
          end
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    owner_valid  = owner_q ? req1_valid_i : req0_valid_i;
    owner_data   = owner_q ? req1_data_i : req0_data_i;
    grant_rdy    = (state_q == W_OWN) && !fifo_full_i;
    req0_ready_o = grant_rdy && !owner_q;
    req1_ready_o = grant_rdy && owner_q;
    own_xfer     = grant_rdy && owner_valid;
    pad_wr       = (state_q == W_PAD) && !fifo_full_i;
    fifo_wr_o    = own_xfer || pad_wr;
    if (own_xfer) begin
      fifo_wdata_o = owner_data;
    end else if (pad_wr) begin
      fifo_wdata_o = PAD_BYTE;
    end else begin
      fifo_wdata_o = 8'h00;
    end
  end

  assign owner_o   = owner_q;
  assign pad_cnt_o = pad_cnt_q;

  uart_word_drain u_drain (
    .clk          (sclk),
    .rst          (rst),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_o    (fifo_rd_o),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i)
  );

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl with a behavioural 16-byte packing FIFO.
module tb_uart_fifo_ctrl;

  logic        sclk = 1'b0;
  logic        rst  = 1'b1;
  logic        req0_valid_i = 1'b0;
  logic [7:0]  req0_data_i  = 8'h00;
  logic        req0_ready_o;
  logic        req1_valid_i = 1'b0;
  logic [7:0]  req1_data_i  = 8'h00;
  logic        req1_ready_o;
  logic [7:0]  fifo_wdata_o;
  logic        fifo_wr_o;
  logic [31:0] fifo_rdata_i;
  logic        fifo_rd_o;
  logic        fifo_empty_i;
  logic        fifo_full_i;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i = 1'b0;
  logic        owner_o;
  logic [7:0]  pad_cnt_o;

  // clock / reset
  always #5 sclk = ~sclk;

  uart_fifo_ctrl dut (
    .sclk         (sclk),
    .rst          (rst),
    .req0_valid_i (req0_valid_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .fifo_wdata_o (fifo_wdata_o),
    .fifo_wr_o    (fifo_wr_o),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rd_o    (fifo_rd_o),
    .fifo_empty_i (fifo_empty_i),
    .fifo_full_i  (fifo_full_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .owner_o      (owner_o),
    .pad_cnt_o    (pad_cnt_o)
  );

  // FIFO model: 16 bytes, pops 4 at a time, byte0 in [7:0]
  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  logic [4:0] cnt;

  always @(posedge sclk or posedge rst) begin
    if (rst) begin
      wp  <= 4'd0;
      rp  <= 4'd0;
      cnt <= 5'd0;
    end else begin
      if (fifo_wr_o) begin
        mem[wp] <= fifo_wdata_o;
        wp      <= wp + 4'd1;
      end
      if (fifo_rd_o) rp <= rp + 4'd4;
      cnt <= cnt + {4'd0, fifo_wr_o} - (fifo_rd_o ? 5'd4 : 5'd0);
    end
  end

  assign fifo_full_i  = (cnt == 5'd16);
  assign fifo_empty_i = (cnt < 5'd4);
  assign fifo_rdata_i = {mem[rp + 4'd3], mem[rp + 4'd2], mem[rp + 4'd1], mem[rp]};

  // bookkeeping
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 1;   // 0: ready low, 1: ready high, 2: random
  int acc0 = 0;
  int wr_viol = 0, rd_viol = 0, hold_viol = 0;
  logic pend0 = 1'b0, pend1 = 1'b0;
  logic hold_prev = 1'b0;
  logic [31:0] prev_w = 32'h0;
  logic [7:0]  src0_q[$];
  logic [7:0]  src1_q[$];
  logic [31:0] got_q[$];
  int          got_t[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [31:0] got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 32'hDEADBEEF;
  endfunction

  // driver + output monitor, all on the falling edge
  always @(negedge sclk) begin
    cyc++;
    if (rst) begin
      pend0 = 1'b0;
      pend1 = 1'b0;
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
      word_ready_i = 1'b0;
    end else begin
      if (pend0) begin
        void'(src0_q.pop_front());
        acc0++;
      end
      if (pend1) void'(src1_q.pop_front());
      req0_valid_i = (src0_q.size() != 0);
      req0_data_i  = req0_valid_i ? src0_q[0] : 8'h00;
      req1_valid_i = (src1_q.size() != 0);
      req1_data_i  = req1_valid_i ? src1_q[0] : 8'h00;
      // ready does not depend on valid and is stable until the next rising edge
      pend0 = req0_valid_i && req0_ready_o;
      pend1 = req1_valid_i && req1_ready_o;
      case (rdy_mode)
        0:       word_ready_i = 1'b0;
        1:       word_ready_i = 1'b1;
        default: word_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (word_valid_o && word_ready_i) begin
        got_q.push_back(word_o);
        got_t.push_back(cyc);
      end
    end
  end

  // protocol watch, after combinational settling
  always begin
    @(negedge sclk);
    #2;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (fifo_wr_o && fifo_full_i) wr_viol++;
      if (fifo_rd_o && fifo_empty_i) rd_viol++;
      if (hold_prev && (!word_valid_o || word_o != prev_w)) hold_viol++;
      hold_prev = word_valid_o && !word_ready_i;
      prev_w    = word_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sclk);
    #2;
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    check(tag, got_q.size(), n);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    src0_q.delete();
    src1_q.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
    got_q.delete();
    got_t.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b0 [16];
    logic [7:0] b1 [16];

    // reset state
    tick(3);
    check("rst_valid", word_valid_o, 0);
    check("rst_word", word_o, 0);
    check("rst_wr", fifo_wr_o, 0);
    check("rst_rd", fifo_rd_o, 0);
    check("rst_rdy0", req0_ready_o, 0);
    check("rst_rdy1", req1_ready_o, 0);
    check("rst_owner", owner_o, 0);
    check("rst_padcnt", pad_cnt_o, 0);
    rst = 1'b0;
    tick(1);

    // 1: single requester, latency
    src0_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    tick(1);
    check("t1_grant_lat", req0_ready_o, 0);
    tick(1);
    check("t1_rdy0", req0_ready_o, 1);
    check("t1_rdy1", req1_ready_o, 0);
    check("t1_wr", fifo_wr_o, 1);
    check("t1_wdata", fifo_wdata_o, 8'h11);
    tick(3);
    check("t1_wdata4", fifo_wdata_o, 8'h44);
    check("t1_valid_early", word_valid_o, 0);
    tick(1);
    check("t1_rd", fifo_rd_o, 1);
    check("t1_valid_pre", word_valid_o, 0);
    tick(1);
    check("t1_valid", word_valid_o, 1);
    check("t1_word", word_o, 32'h44332211);
    check("t1_owner", owner_o, 0);

    // 2: both requesters, round-robin from rr=0
    pulse_reset();
    src0_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    src1_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    wait_words("t2_count", 2, 60);
    check("t2_word0", got_at(0), 32'hA3A2A1A0);
    check("t2_word1", got_at(1), 32'hB3B2B1B0);
    check("t2_owner", owner_o, 1);

    // 3: backpressure until full, then drain
    got_q.delete();
    got_t.delete();
    rdy_mode = 0;
    acc0 = 0;
    for (int i = 0; i < 24; i++) src0_q.push_back(8'(8'hC0 + i));
    tick(60);
    check("t3_accepted", acc0, 20);
    check("t3_full", fifo_full_i, 1);
    check("t3_rdy0", req0_ready_o, 0);
    check("t3_pending", src0_q.size(), 4);
    check("t3_valid", word_valid_o, 1);
    rdy_mode = 1;
    wait_words("t3_count", 6, 80);
    for (int k = 0; k < 6; k++)
      check($sformatf("t3_word%0d", k), got_at(k),
            pack(8'(8'hC0 + 4*k), 8'(8'hC1 + 4*k), 8'(8'hC2 + 4*k), 8'(8'hC3 + 4*k)));
    for (int k = 0; k < 4; k++)
      check($sformatf("t3_gap%0d", k), (got_t.size() > k + 1) ? got_t[k+1] - got_t[k] : 0, 1);

    // 4: stalled partial word gets padded, then req1 is served
    got_q.delete();
    src0_q = '{8'hAA, 8'hBB};
    tick(19);
    check("t4_pad_early", fifo_wr_o, 0);
    tick(1);
    check("t4_pad_wr", fifo_wr_o, 1);
    check("t4_pad_data", fifo_wdata_o, 8'h00);
    wait_words("t4_count", 1, 20);
    check("t4_word", got_at(0), 32'h0000BBAA);
    check("t4_padcnt", pad_cnt_o, 1);
    src1_q = '{8'h51, 8'h52, 8'h53, 8'h54};
    wait_words("t4_count2", 2, 30);
    check("t4_word_req1", got_at(1), 32'h54535251);
    check("t4_owner", owner_o, 1);

    // 5: reset in the middle of a word
    got_q.delete();
    src0_q = '{8'hE0, 8'hE1};
    tick(4);
    rst = 1'b1;
    src0_q.delete();
    tick(1);
    check("t5_valid", word_valid_o, 0);
    check("t5_word", word_o, 0);
    check("t5_wr", fifo_wr_o, 0);
    check("t5_rdy0", req0_ready_o, 0);
    check("t5_owner", owner_o, 0);
    check("t5_padcnt", pad_cnt_o, 0);
    check("t5_empty", fifo_empty_i, 1);
    rst = 1'b0;
    tick(1);
    got_q.delete();
    src0_q = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
    wait_words("t5_count", 1, 40);
    check("t5_clean_word", got_at(0), 32'hF3F2F1F0);
    tick(25);
    check("t5_no_extra", got_q.size(), 1);
    check("t5_padcnt_after", pad_cnt_o, 0);

    // 6: random downstream ready, two streams; rr=1 so req1 leads
    got_q.delete();
    exp_q.delete();
    rdy_mode = 2;
    for (int i = 0; i < 16; i++) begin
      b0[i] = 8'($urandom_range(0, 255));
      b1[i] = 8'($urandom_range(0, 255));
      src0_q.push_back(b0[i]);
      src1_q.push_back(b1[i]);
    end
    for (int w = 0; w < 4; w++) begin
      exp_q.push_back(pack(b1[4*w], b1[4*w+1], b1[4*w+2], b1[4*w+3]));
      exp_q.push_back(pack(b0[4*w], b0[4*w+1], b0[4*w+2], b0[4*w+3]));
    end
    wait_words("t6_count", 8, 600);
    for (int k = 0; k < 8; k++)
      check($sformatf("t6_word%0d", k), got_at(k), exp_q[k]);
    rdy_mode = 1;
    tick(5);

    check("wr_when_full", wr_viol, 0);
    check("rd_when_empty", rd_viol, 0);
    check("word_hold", hold_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
